// File: rtl/conv2_ch_sched.sv
`default_nettype none
// ============================================================================
// conv2_ch_sched : replays each conv2 window once per output channel on a
//                  shared datapath and tags results with channel/position.
// Revision: 1.0
// ============================================================================
module conv2_ch_sched #(
  parameter int WIDTH       = 12,
  parameter int HEIGHT      = 12,
  parameter int FILTER_SIZE = 5,
  parameter int NUM_CH      = 3,
  parameter int CALC_LAT    = 1,
  localparam int OUT_W      = WIDTH - FILTER_SIZE + 1,
  localparam int OUT_H      = HEIGHT - FILTER_SIZE + 1,
  localparam int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int MAX_POS    = (OUT_W > OUT_H) ? OUT_W : OUT_H,
  localparam int POS_BITS   = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                win_valid,
  output logic                win_ready,
  output logic                win_hold,
  output logic                calc_en,
  output logic [CH_BITS-1:0]  ch_sel,
  output logic                out_valid,
  output logic [CH_BITS-1:0]  out_ch,
  output logic [POS_BITS-1:0] out_row,
  output logic [POS_BITS-1:0] out_col,
  output logic                frame_done,
  output logic                busy
);

  localparam int STG_W = 1 + CH_BITS + 2 * POS_BITS + 1;
  localparam int VB    = STG_W - 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(NUM_CH - 1);
  localparam logic [POS_BITS-1:0] COL_LAST = POS_BITS'(OUT_W - 1);
  localparam logic [POS_BITS-1:0] ROW_LAST = POS_BITS'(OUT_H - 1);

  logic [0:0]          state_q, state_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic [POS_BITS-1:0] row_q, row_d, col_q, col_d;
  logic [POS_BITS-1:0] tag_row_q, tag_row_d, tag_col_q, tag_col_d;
  logic                tag_last_q, tag_last_d;
  logic [STG_W-1:0]    pipe_q [CALC_LAT];
  logic [STG_W-1:0]    pipe_d [CALC_LAT];

  logic is_last_ch;
  logic accept;
  logic out_last;
  logic pipe_any;

  assign is_last_ch = (ch_q == CH_LAST);
  assign accept     = win_valid & win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      tag_row_q  <= '0;
      tag_col_q  <= '0;
      tag_last_q <= 1'b0;
      for (int i = 0; i < CALC_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tag_row_q  <= tag_row_d;
      tag_col_q  <= tag_col_d;
      tag_last_q <= tag_last_d;
      for (int i = 0; i < CALC_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          ch_d    = '0;
        end
      end
      default: begin
        if (!is_last_ch) begin
          ch_d = ch_q + 1'b1;
        end else begin
          ch_d    = '0;
          state_d = accept ? ST_ISSUE : ST_IDLE;
        end
      end
    endcase
  end

  // Hold drops on the final channel only when the buffer is being advanced.
  always_comb begin
    win_ready = 1'b1;
    win_hold  = 1'b0;
    calc_en   = 1'b0;
    ch_sel    = '0;
    if (state_q == ST_ISSUE) begin
      calc_en   = 1'b1;
      ch_sel    = ch_q;
      win_ready = is_last_ch;
      win_hold  = !(is_last_ch && win_valid);
    end
  end

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    tag_row_d  = tag_row_q;
    tag_col_d  = tag_col_q;
    tag_last_d = tag_last_q;
    if (accept) begin
      tag_row_d  = row_q;
      tag_col_d  = col_q;
      tag_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    pipe_d[0] = {calc_en, ch_sel, tag_row_q, tag_col_q, tag_last_q};
    for (int i = 1; i < CALC_LAT; i++) pipe_d[i] = pipe_q[i-1];
    pipe_any = 1'b0;
    for (int i = 0; i < CALC_LAT; i++) pipe_any = pipe_any | pipe_q[i][VB];
  end

  assign {out_valid, out_ch, out_row, out_col, out_last} = pipe_q[CALC_LAT-1];
  assign frame_done = out_valid & (out_ch == CH_LAST) & out_last;
  assign busy       = (state_q == ST_ISSUE) | pipe_any;

endmodule
`default_nettype wire

// File: tb/tb_conv2_ch_sched.sv
`default_nettype none
// ============================================================================
// tb_conv2_ch_sched : two scheduler configurations (3 ch / lat 1, 1 ch / lat 3)
//                     against a cycle-indexed schedule model.
// Revision: 1.0
// ============================================================================
module tb_conv2_ch_sched;

  localparam int M     = 64;
  localparam int OUT_W = 8;
  localparam int OUT_H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1, wv0, wv1;
  logic       wr0, wh0, ce0, ov0, fd0, bz0;
  logic [1:0] cs0, oc0;
  logic [2:0] orow0, ocol0;
  logic       wr1, wh1, ce1, ov1, fd1, bz1;
  logic [0:0] cs1, oc1;
  logic [2:0] orow1, ocol1;

  conv2_ch_sched #(.WIDTH(12), .HEIGHT(12), .FILTER_SIZE(5), .NUM_CH(3), .CALC_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n0), .win_valid(wv0), .win_ready(wr0), .win_hold(wh0),
    .calc_en(ce0), .ch_sel(cs0), .out_valid(ov0), .out_ch(oc0), .out_row(orow0),
    .out_col(ocol0), .frame_done(fd0), .busy(bz0)
  );

  conv2_ch_sched #(.WIDTH(12), .HEIGHT(12), .FILTER_SIZE(5), .NUM_CH(1), .CALC_LAT(3)) dut1 (
    .clk(clk), .rst_n(rst_n1), .win_valid(wv1), .win_ready(wr1), .win_hold(wh1),
    .calc_en(ce1), .ch_sel(cs1), .out_valid(ov1), .out_ch(oc1), .out_row(orow1),
    .out_col(ocol1), .frame_done(fd1), .busy(bz1)
  );

  // Expected behaviour per cycle slot, filled in when a window is accepted.
  bit e_calc [2][M];
  int e_ch   [2][M];
  bit e_ov   [2][M];
  int e_och  [2][M];
  int e_row  [2][M];
  int e_col  [2][M];
  bit e_done [2][M];
  bit e_busy [2][M];
  int free_at [2];
  int nwin    [2];
  int obs_done_cnt [2];
  int cyc, n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < M; i++) begin
      e_calc[d][i] = 0; e_ch[d][i] = 0; e_ov[d][i] = 0; e_och[d][i] = 0;
      e_row[d][i] = 0; e_col[d][i] = 0; e_done[d][i] = 0; e_busy[d][i] = 0;
    end
    free_at[d] = 0;
    nwin[d]    = 0;
  endtask

  task automatic check(input int d, input bit v, input bit r);
    logic [31:0] o_wr, o_wh, o_ce, o_cs, o_ov, o_oc, o_or, o_ocl, o_fd, o_bz;
    int  idx, nch, lat, wr, wc, t;
    bit  rdy, acc, lastch;
    idx = cyc % M;
    nch = (d == 0) ? 3 : 1;
    lat = (d == 0) ? 1 : 3;
    if (d == 0) begin
      o_wr = 32'(wr0); o_wh = 32'(wh0); o_ce = 32'(ce0); o_cs = 32'(cs0); o_ov = 32'(ov0);
      o_oc = 32'(oc0); o_or = 32'(orow0); o_ocl = 32'(ocol0); o_fd = 32'(fd0); o_bz = 32'(bz0);
    end else begin
      o_wr = 32'(wr1); o_wh = 32'(wh1); o_ce = 32'(ce1); o_cs = 32'(cs1); o_ov = 32'(ov1);
      o_oc = 32'(oc1); o_or = 32'(orow1); o_ocl = 32'(ocol1); o_fd = 32'(fd1); o_bz = 32'(bz1);
    end
    rdy    = (cyc >= free_at[d]);
    acc    = v && r && rdy;
    lastch = e_calc[d][idx] && (e_ch[d][idx] == nch - 1);
    chk($sformatf("d%0d.win_ready", d), o_wr, 32'(rdy));
    chk($sformatf("d%0d.win_hold", d), o_wh, 32'(e_calc[d][idx] && !(lastch && acc)));
    chk($sformatf("d%0d.calc_en", d), o_ce, 32'(e_calc[d][idx]));
    chk($sformatf("d%0d.out_valid", d), o_ov, 32'(e_ov[d][idx]));
    chk($sformatf("d%0d.frame_done", d), o_fd, 32'(e_done[d][idx]));
    chk($sformatf("d%0d.busy", d), o_bz, 32'(e_busy[d][idx]));
    if (e_calc[d][idx] || !r)
      chk($sformatf("d%0d.ch_sel", d), o_cs, 32'(e_ch[d][idx]));
    if (e_ov[d][idx] || !r) begin
      chk($sformatf("d%0d.out_ch", d), o_oc, 32'(e_och[d][idx]));
      chk($sformatf("d%0d.out_row", d), o_or, 32'(e_row[d][idx]));
      chk($sformatf("d%0d.out_col", d), o_ocl, 32'(e_col[d][idx]));
    end
    if (o_fd === 32'd1) obs_done_cnt[d]++;
    if (acc) begin
      wr = (nwin[d] / OUT_W) % OUT_H;
      wc = nwin[d] % OUT_W;
      for (int j = 0; j < nch; j++) begin
        t = (cyc + 1 + j) % M;
        e_calc[d][t] = 1; e_ch[d][t] = j;
        t = (cyc + 1 + j + lat) % M;
        e_ov[d][t] = 1; e_och[d][t] = j; e_row[d][t] = wr; e_col[d][t] = wc;
        e_done[d][t] = (j == nch - 1) && (wr == OUT_H - 1) && (wc == OUT_W - 1);
      end
      for (int k = cyc + 1; k <= cyc + nch + lat; k++) e_busy[d][k % M] = 1;
      nwin[d]++;
      free_at[d] = cyc + nch;
    end
    e_calc[d][idx] = 0; e_ch[d][idx] = 0; e_ov[d][idx] = 0; e_och[d][idx] = 0;
    e_row[d][idx] = 0; e_col[d][idx] = 0; e_done[d][idx] = 0; e_busy[d][idx] = 0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
  task automatic step(input bit v0, input bit v1, input bit r0, input bit r1);
    @(posedge clk);
    cyc++;
    #1;
    wv0 = v0; wv1 = v1; rst_n0 = r0; rst_n1 = r1;
    if (!r0) clear_model(0);
    if (!r1) clear_model(1);
    #1;
    check(0, v0, r0);
    check(1, v1, r1);
  endtask

  initial begin
    int g, n0;
    rst_n0 = 1'b0; rst_n1 = 1'b0; wv0 = 1'b0; wv1 = 1'b0;
    cyc = 0; n_chk = 0; n_pass = 0;
    obs_done_cnt[0] = 0; obs_done_cnt[1] = 0;
    clear_model(0);
    clear_model(1);

    for (int i = 0; i < 4; i++) step(i[0], i[0], 1'b0, 1'b0);
    step(0, 0, 1, 1);

    step(1, 0, 1, 1);
    repeat (7) step(0, 0, 1, 1);

    repeat (13) step(1, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      if (e_calc[0][(cyc + 1) % M] && e_ch[0][(cyc + 1) % M] == 1) break;
      step(1, 0, 1, 1);
    end
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 1);

    for (int w = 0; w < 65; w++) begin
      g = int'($urandom_range(3, 0));
      repeat (g) step(0, 0, 1, 1);
      n0 = nwin[0];
      while (nwin[0] == n0) step(1, 0, 1, 1);
    end
    repeat (6) step(0, 0, 1, 1);

    repeat (70) step(0, 1, 1, 1);
    repeat (6) step(0, 0, 1, 1);

    chk("d0.frame_done_count", 32'(obs_done_cnt[0]), 32'd1);
    chk("d1.frame_done_count", 32'(obs_done_cnt[1]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
